// File: rtl/input_port_buffer_pkg.sv
// rtl/input_port_buffer_pkg.sv - router packet type and link constants
package input_port_buffer_pkg;

    localparam int LINK_W    = 8;
    localparam int PKT_BYTES = 4;
    localparam int PKT_W     = LINK_W * PKT_BYTES;

    // dest occupies the first byte on the link so routing can decode it from the head
    typedef struct packed {
        logic [7:0]  dest;
        logic [23:0] data;
    } pkt_t;

endpackage

// File: rtl/input_port_buffer_sync_fifo.sv
// rtl/input_port_buffer_sync_fifo.sv - show-ahead synchronous packet FIFO
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    a_no_push_full: assert property (@(posedge clock) disable iff (reset) !(push && full));
    a_no_pop_empty: assert property (@(posedge clock) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/input_port_buffer.sv
// rtl/input_port_buffer.sv - router ingress: byte deserialiser feeding a packet FIFO
module input_port_buffer
    import input_port_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PORTID = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     put_inbound,
    input  logic [LINK_W-1:0]        payload_in,
    output logic                     free_inbound,
    input  logic                     read_from_ib,
    output logic                     pkt_avail,
    output pkt_t                     pkt_out,
    output logic                     pkt_err,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;
    localparam logic [1:0] LAST = 2'(PKT_BYTES - 1);

    logic [0:0]          state;
    logic [1:0]          cnt;
    logic [PKT_W-9:0]    shreg;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic [PKT_W-1:0]    fifo_head;

    // Slot is reserved on entry to RECV, so the final push can never meet a full FIFO
    assign free_inbound = (state == IDLE) && !fifo_full;
    assign push         = (state == RECV) && put_inbound && (cnt == LAST);
    assign pop          = read_from_ib && !fifo_empty;
    assign pkt_avail    = !fifo_empty;
    assign pkt_out      = pkt_t'(fifo_head);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            pkt_err <= 1'b0;
        end else begin
            pkt_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (put_inbound) begin
                        if (free_inbound) begin
                            shreg <= {shreg[PKT_W-17:0], payload_in};
                            cnt   <= 2'd1;
                            state <= RECV;
                        end else begin
                            pkt_err <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (put_inbound) begin
                        shreg <= {shreg[PKT_W-17:0], payload_in};
                        cnt   <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state <= IDLE;
                        end
                    end else begin
                        pkt_err <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   ({shreg, payload_in}),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy),
        .head  (fifo_head)
    );

    a_recv_not_free: assert property (@(posedge clock) disable iff (reset)
        (state == RECV) |-> !free_inbound)
        else $error("port %0d: free_inbound high during RECV", PORTID);

endmodule

// File: tb/tb_input_port_buffer.sv
// tb/tb_input_port_buffer.sv - directed self-checking bench for input_port_buffer
module tb_input_port_buffer;

    logic        clock;
    logic        reset;
    logic        put_inbound;
    logic [7:0]  payload_in;
    logic        free_inbound;
    logic        read_from_ib;
    logic        pkt_avail;
    logic [31:0] pkt_out;
    logic        pkt_err;
    logic [2:0]  occupancy;

    int n_checks = 0;
    int n_pass   = 0;

    input_port_buffer #(.DEPTH(4), .PORTID(0)) dut (
        .clock        (clock),
        .reset        (reset),
        .put_inbound  (put_inbound),
        .payload_in   (payload_in),
        .free_inbound (free_inbound),
        .read_from_ib (read_from_ib),
        .pkt_avail    (pkt_avail),
        .pkt_out      (pkt_out),
        .pkt_err      (pkt_err),
        .occupancy    (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_pkt(input logic [31:0] pkt);
        logic [31:0] p;
        p = pkt;
        for (int i = 0; i < 4; i++) begin
            put_inbound = 1'b1;
            payload_in  = p[31 - 8*i -: 8];
            step();
        end
        put_inbound = 1'b0;
        payload_in  = 8'h00;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp);
        check(tag, pkt_out, exp);
        read_from_ib = 1'b1;
        step();
        read_from_ib = 1'b0;
    endtask

    initial begin
        logic [31:0] p;
        reset        = 1'b1;
        put_inbound  = 1'b0;
        payload_in   = 8'h00;
        read_from_ib = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_free", {31'b0, free_inbound}, 32'd1);
        check("rst_avail", {31'b0, pkt_avail}, 32'd0);
        check("rst_pkt_out", pkt_out, 32'h0);
        check("rst_err", {31'b0, pkt_err}, 32'd0);
        check("rst_occ", {29'b0, occupancy}, 32'd0);

        // 1: single packet
        put_inbound = 1'b1;
        payload_in  = 8'h12;
        step();
        check("t1_free_in_recv", {31'b0, free_inbound}, 32'd0);
        check("t1_avail_early", {31'b0, pkt_avail}, 32'd0);
        payload_in = 8'h34; step();
        payload_in = 8'h56; step();
        payload_in = 8'h78; step();
        put_inbound = 1'b0;
        check("t1_avail", {31'b0, pkt_avail}, 32'd1);
        check("t1_pkt_out", pkt_out, 32'h12345678);
        check("t1_occ", {29'b0, occupancy}, 32'd1);
        check("t1_free_after", {31'b0, free_inbound}, 32'd1);

        // 2: fill FIFO, then overflow attempt
        send_pkt(32'h1111_0001);
        send_pkt(32'h2222_0002);
        send_pkt(32'h3333_0003);
        check("t2_occ_full", {29'b0, occupancy}, 32'd4);
        check("t2_free_full", {31'b0, free_inbound}, 32'd0);
        put_inbound = 1'b1;
        payload_in  = 8'hEE;
        step();
        put_inbound = 1'b0;
        check("t2_err_pulse", {31'b0, pkt_err}, 32'd1);
        check("t2_occ_stays", {29'b0, occupancy}, 32'd4);
        step();
        check("t2_err_clear", {31'b0, pkt_err}, 32'd0);
        check("t2_head", pkt_out, 32'h12345678);

        // 3: one pop frees a slot, order preserved
        read_from_ib = 1'b1;
        step();
        read_from_ib = 1'b0;
        check("t3_occ", {29'b0, occupancy}, 32'd3);
        check("t3_free", {31'b0, free_inbound}, 32'd1);
        check("t3_head", pkt_out, 32'h1111_0001);
        send_pkt(32'h4444_0004);
        check("t3_occ_refill", {29'b0, occupancy}, 32'd4);
        pop_check("t3_order0", 32'h1111_0001);
        pop_check("t3_order1", 32'h2222_0002);
        pop_check("t3_order2", 32'h3333_0003);
        pop_check("t3_order3", 32'h4444_0004);
        check("t3_occ_empty", {29'b0, occupancy}, 32'd0);
        check("t3_avail_empty", {31'b0, pkt_avail}, 32'd0);

        // 4: push and pop on the same edge with occupancy 1
        send_pkt(32'h9999_0001);
        check("t4_occ_pre", {29'b0, occupancy}, 32'd1);
        p = 32'hA5A5_0003;
        for (int i = 0; i < 4; i++) begin
            put_inbound  = 1'b1;
            payload_in   = p[31 - 8*i -: 8];
            read_from_ib = (i == 3);
            step();
        end
        put_inbound  = 1'b0;
        read_from_ib = 1'b0;
        check("t4_occ", {29'b0, occupancy}, 32'd1);
        check("t4_head", pkt_out, 32'hA5A5_0003);
        pop_check("t4_pop", 32'hA5A5_0003);
        check("t4_occ_after", {29'b0, occupancy}, 32'd0);

        // 5: truncated packet
        put_inbound = 1'b1;
        payload_in  = 8'hC1; step();
        payload_in  = 8'hC2; step();
        put_inbound = 1'b0;
        step();
        check("t5_err", {31'b0, pkt_err}, 32'd1);
        check("t5_occ", {29'b0, occupancy}, 32'd0);
        check("t5_free", {31'b0, free_inbound}, 32'd1);
        step();
        check("t5_err_clear", {31'b0, pkt_err}, 32'd0);
        send_pkt(32'hDEAD_BEEF);
        check("t5_recover_occ", {29'b0, occupancy}, 32'd1);
        check("t5_recover_head", pkt_out, 32'hDEAD_BEEF);

        // 6: reset mid-packet with 3 queued
        send_pkt(32'h5555_0005);
        send_pkt(32'h6666_0006);
        check("t6_occ_pre", {29'b0, occupancy}, 32'd3);
        put_inbound = 1'b1;
        payload_in  = 8'h71; step();
        payload_in  = 8'h72; step();
        payload_in  = 8'h73;
        reset       = 1'b1;
        step();
        reset       = 1'b0;
        put_inbound = 1'b0;
        check("t6_free", {31'b0, free_inbound}, 32'd1);
        check("t6_avail", {31'b0, pkt_avail}, 32'd0);
        check("t6_pkt_out", pkt_out, 32'h0);
        check("t6_err", {31'b0, pkt_err}, 32'd0);
        check("t6_occ", {29'b0, occupancy}, 32'd0);
        read_from_ib = 1'b1;
        step();
        read_from_ib = 1'b0;
        check("t6_empty_read_occ", {29'b0, occupancy}, 32'd0);
        check("t6_empty_read_avail", {31'b0, pkt_avail}, 32'd0);
        check("t6_empty_read_err", {31'b0, pkt_err}, 32'd0);
        send_pkt(32'h0BAD_F00D);
        check("t6_post_head", pkt_out, 32'h0BAD_F00D);
        check("t6_post_occ", {29'b0, occupancy}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
